// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared constants for the MMIO controller: register offsets within the MMIO
// window (decoded from addr[7:0]), status-register bit positions and a helper
// that assembles the status word.
// -----------------------------------------------------------------------------
package mmio_pkg;

  // Register offsets (byte address bits [7:0])
  localparam logic [7:0] OFF_STATUS  = 8'h00;  // R : status
  localparam logic [7:0] OFF_RX_DATA = 8'h04;  // R : RX head byte, pops FIFO
  localparam logic [7:0] OFF_TX_DATA = 8'h08;  // W : TX holding register
  localparam logic [7:0] OFF_CYCLE   = 8'h10;  // R : cycle counter
  localparam logic [7:0] OFF_INSTR   = 8'h14;  // R : retired-instruction counter
  localparam logic [7:0] OFF_CNT_CLR = 8'h18;  // W : zero both counters

  // Status register bit positions
  localparam int STAT_TX_FREE_BIT  = 0;
  localparam int STAT_RX_AVAIL_BIT = 1;

  // Status word: TX holding register free, RX FIFO holds data; all else 0.
  function automatic logic [31:0] status_word(input logic tx_free,
                                              input logic rx_avail);
    logic [31:0] w;
    w                    = '0;
    w[STAT_TX_FREE_BIT]  = tx_free;
    w[STAT_RX_AVAIL_BIT] = rx_avail;
    return w;
  endfunction

endpackage : mmio_pkg

// File: rtl/mmio_fifo.sv
// -----------------------------------------------------------------------------
// mmio_fifo
// Synchronous first-word-fall-through FIFO. dout always shows the head entry
// (undefined when empty). Push while full and pop while empty are ignored, so
// callers may gate loosely. Simultaneous push and pop are both honoured when
// neither guard blocks them.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  entry width in bits
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (empties the FIFO)
//   push   in   write din this cycle
//   pop    in   discard head entry this cycle
//   din    in   WIDTH  write data
//   dout   out  WIDTH  head entry
//   full   out  all DEPTH entries occupied
//   empty  out  no entries occupied
// -----------------------------------------------------------------------------
module mmio_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule : mmio_fifo

// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
// Memory-mapped I/O block in parallel with the data memory. Decodes the
// EX-stage access, owns the UART TX holding register, the RX byte FIFO and the
// cycle / retired-instruction counters, and returns registered read data one
// cycle after the load, aligned with the data BRAM.
//
// Parameters:
//   RX_DEPTH          RX FIFO entries (power of two, >= 2)
//   MMIO_BASE_NIBBLE  addr[31:28] value selecting MMIO space
// Ports:
//   clk            in   core clock
//   reset          in   synchronous active-high reset
//   addr           in   32  EX-stage byte address
//   wdata          in   32  store data
//   wea            in   4   byte write enables (any set = store)
//   re             in   load in EX this cycle
//   instr_retire   in   one pulse per retiring non-bubble instruction
//   io_sel         out  previous load hit MMIO (top-level read mux select)
//   rdata          out  32  registered MMIO read data
//   uart_tx_data   out  8   byte to UART transmitter
//   uart_tx_valid  out  TX holding register full
//   uart_tx_ready  in   transmitter accepts byte
//   uart_rx_data   in   8   received byte
//   uart_rx_valid  in   receiver has a byte
//   uart_rx_ready  out  RX FIFO not full
// -----------------------------------------------------------------------------
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int         RX_DEPTH         = 4,
  parameter logic [3:0] MMIO_BASE_NIBBLE = 4'h8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic        instr_retire,
  output logic        io_sel,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [31:0] r_rdata;
  logic        r_io_sel;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       w_hit;
  logic       w_store;
  logic       w_load;
  logic [7:0] w_off;

  assign w_hit   = (addr[31:28] == MMIO_BASE_NIBBLE);
  assign w_store = w_hit & (|wea);
  assign w_load  = w_hit & re;
  assign w_off   = addr[7:0];

  // Address bits between the window nibble and the offset byte, and the upper
  // store-data bits, are don't-care for this block.
  logic w_unused;
  assign w_unused = &{1'b0, addr[27:8], wdata[31:8]};

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;
  logic       w_rx_push;
  logic       w_rx_pop;

  // Ready depends only on occupancy: when full, a same-cycle pop does not
  // open the door, so the sender sees a clean, valid-independent ready.
  assign uart_rx_ready = ~w_rx_full;
  assign w_rx_push     = uart_rx_valid & ~w_rx_full;
  // A load of RX data while empty returns 0 and leaves the FIFO alone, even if
  // a byte is being pushed in that same cycle.
  assign w_rx_pop      = w_load & (w_off == OFF_RX_DATA) & ~w_rx_empty;

  mmio_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (uart_rx_data),
    .dout  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  // ---------------------------------------------------------------------------
  // TX holding register
  // ---------------------------------------------------------------------------
  logic w_tx_store;
  logic w_tx_done;
  logic w_tx_accept;

  assign w_tx_store  = w_store & (w_off == OFF_TX_DATA);
  assign w_tx_done   = r_tx_valid & uart_tx_ready;
  // The register is free either when empty or when its byte leaves this very
  // cycle, so a store coinciding with the handshake is not lost.
  assign w_tx_accept = w_tx_store & (~r_tx_valid | w_tx_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_tx_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= wdata[7:0];
    end else if (w_tx_done) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign uart_tx_valid = r_tx_valid;
  assign uart_tx_data  = r_tx_data;

  // ---------------------------------------------------------------------------
  // Cycle and retired-instruction counters
  // ---------------------------------------------------------------------------
  logic w_cnt_clr;
  assign w_cnt_clr = w_store & (w_off == OFF_CNT_CLR);

  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) begin
      // Clear wins over the same-cycle increment.
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (instr_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (state as of this cycle, before this cycle's updates)
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_val;

  // NOTE: the default assignment first guarantees every path drives w_rd_val,
  // so no latch is inferred for offsets the case does not list.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_STATUS:  w_rd_val = status_word(~r_tx_valid, ~w_rx_empty);
      OFF_RX_DATA: w_rd_val = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      OFF_CYCLE:   w_rd_val = r_cycle_cnt;
      OFF_INSTR:   w_rd_val = r_instr_cnt;
      default:     w_rd_val = '0;
    endcase
  end

  // Any load updates the read registers; a non-MMIO load drops io_sel so the
  // top-level mux selects the data memory. Between loads the values hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_io_sel <= 1'b0;
    end else if (re) begin
      r_io_sel <= w_hit;
      r_rdata  <= w_load ? w_rd_val : 32'd0;
    end
  end

  assign rdata  = r_rdata;
  assign io_sel = r_io_sel;

endmodule : mmio_ctrl

// File: tb/tb_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_ctrl
// Directed bench for mmio_ctrl. Load stimulus pushes its hand-computed result
// into a queue; a monitor pops and compares one cycle after every load. State
// visible on the UART ports is checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wea;
  logic        re;
  logic        instr_retire;
  logic        io_sel;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        io_sel;
    logic        chk_data;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  mmio_ctrl #(
    .RX_DEPTH         (4),
    .MMIO_BASE_NIBBLE (4'h8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .wdata         (wdata),
    .wea           (wea),
    .re            (re),
    .instr_retire  (instr_retire),
    .io_sel        (io_sel),
    .rdata         (rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic exp_sel, input logic chk,
                         input string name);
    exp_t e;
    e.rdata    = exp_data;
    e.io_sel   = exp_sel;
    e.chk_data = chk;
    exp_q.push_back(e);
    name_q.push_back(name);
    addr = a;
    re   = 1'b1;
    step();
    re   = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wea   = 4'hF;
    step();
    wea   = 4'h0;
  endtask

  // Monitor: a load sampled at an edge (outside reset) has its result visible
  // just after that edge.
  initial begin
    exp_t  e;
    string nm;
    logic  was_load;
    forever begin
      @(posedge clk);
      was_load = re && !reset;
      #1;
      if (was_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load_result", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_io_sel"}, {31'd0, io_sel}, {31'd0, e.io_sel});
          if (e.chk_data) check({nm, "_rdata"}, rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx_bytes [4];
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22;
    rx_bytes[2] = 8'h33; rx_bytes[3] = 8'h44;

    reset = 1'b1; addr = '0; wdata = '0; wea = '0; re = 1'b0;
    instr_retire = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_data = '0; uart_rx_valid = 1'b0;

    // ---- reset values ----
    step(); step();
    check("rst_rdata",    rdata,                    32'd0);
    check("rst_io_sel",   {31'd0, io_sel},          32'd0);
    check("rst_tx_valid", {31'd0, uart_tx_valid},   32'd0);
    check("rst_tx_data",  {24'd0, uart_tx_data},    32'd0);
    check("rst_rx_ready", {31'd0, uart_rx_ready},   32'd1);
    reset = 1'b0;

    // ---- cycle counter read 5 cycles after reset release ----
    repeat (5) step();
    do_load(32'h8000_0010, 32'd5, 1'b1, 1'b1, "cycle_at_5");
    step();
    check("rdata_hold", rdata, 32'd5);

    // ---- TX holding register ----
    do_store(32'h8000_0008, 32'h0000_0041);
    check("tx_valid_set",  {31'd0, uart_tx_valid}, 32'd1);
    check("tx_data_41",    {24'd0, uart_tx_data},  32'h41);
    do_store(32'h8000_0008, 32'h0000_0042);
    check("tx_full_drop",  {24'd0, uart_tx_data},  32'h41);
    uart_tx_ready = 1'b1;
    step();
    uart_tx_ready = 1'b0;
    check("tx_handshake_clear", {31'd0, uart_tx_valid}, 32'd0);
    do_load(32'h8000_0000, 32'd1, 1'b1, 1'b1, "status_tx_free");
    do_store(32'h8000_0008, 32'h0000_0043);
    uart_tx_ready = 1'b1;
    do_store(32'h8000_0008, 32'h0000_0044);
    check("tx_store_on_hs_valid", {31'd0, uart_tx_valid}, 32'd1);
    check("tx_store_on_hs_data",  {24'd0, uart_tx_data},  32'h44);
    step();
    uart_tx_ready = 1'b0;
    check("tx_drain", {31'd0, uart_tx_valid}, 32'd0);
    do_store(32'h1000_0008, 32'h0000_0099);  // outside MMIO window
    do_store(32'h8000_0020, 32'h0000_0099);  // unmapped offset
    check("tx_ignore_stray_store", {31'd0, uart_tx_valid}, 32'd0);

    // ---- RX FIFO fill, overflow hold-off, drain ----
    for (int i = 0; i < 4; i++) begin
      uart_rx_data  = rx_bytes[i];
      uart_rx_valid = 1'b1;
      step();
    end
    uart_rx_data = 8'h55;  // fifth byte stays offered
    check("rx_full_ready", {31'd0, uart_rx_ready}, 32'd0);
    step();
    check("rx_full_hold", {31'd0, uart_rx_ready}, 32'd0);
    do_load(32'h8000_0000, 32'd3, 1'b1, 1'b1, "status_rx_avail");
    do_load(32'h8000_0004, 32'h11, 1'b1, 1'b1, "rx_pop_full");
    uart_rx_valid = 1'b0;
    check("rx_ready_after_pop", {31'd0, uart_rx_ready}, 32'd1);
    do_load(32'h8000_0004, 32'h22, 1'b1, 1'b1, "rx_pop_2");
    do_load(32'h8000_0004, 32'h33, 1'b1, 1'b1, "rx_pop_3");
    do_load(32'h8000_0004, 32'h44, 1'b1, 1'b1, "rx_pop_4");
    do_load(32'h8000_0004, 32'h00, 1'b1, 1'b1, "rx_pop_empty");
    do_load(32'h8ABC_DE00, 32'd1,  1'b1, 1'b1, "status_empty_hiaddr");
    // push + pop on an empty FIFO: push only, read returns 0
    uart_rx_data  = 8'h66;
    uart_rx_valid = 1'b1;
    do_load(32'h8000_0004, 32'h00, 1'b1, 1'b1, "rx_pushpop_empty");
    uart_rx_valid = 1'b0;
    do_load(32'h8000_0004, 32'h66, 1'b1, 1'b1, "rx_after_pushpop");
    do_load(32'h8000_0004, 32'h00, 1'b1, 1'b1, "rx_empty_again");

    // ---- instruction counter and clear ----
    for (int i = 0; i < 10; i++) begin
      instr_retire = 1'b1;
      step();
      instr_retire = 1'b0;
      step();
    end
    do_load(32'h8000_0014, 32'd10, 1'b1, 1'b1, "instr_10");
    instr_retire = 1'b1;
    do_store(32'h8000_0018, 32'hDEAD_BEEF);
    instr_retire = 1'b0;
    do_load(32'h8000_0014, 32'd0, 1'b1, 1'b1, "instr_cleared");
    do_load(32'h8000_0010, 32'd1, 1'b1, 1'b1, "cycle_after_clear");

    // ---- io_sel and unmapped reads ----
    do_load(32'h8000_0010, 32'd0, 1'b1, 1'b0, "mmio_load");
    do_load(32'h1000_0000, 32'd0, 1'b0, 1'b0, "non_mmio_load");
    do_load(32'h8000_0020, 32'd0, 1'b1, 1'b1, "unmapped_20");
    do_load(32'h8000_0008, 32'd0, 1'b1, 1'b1, "read_tx_reg");

    // ---- reset mid-transfer ----
    do_store(32'h8000_0008, 32'h0000_0077);
    uart_rx_data  = 8'h88;
    uart_rx_valid = 1'b1;
    step();
    uart_rx_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    check("midrst_tx_data",  {24'd0, uart_tx_data},  32'd0);
    check("midrst_io_sel",   {31'd0, io_sel},        32'd0);
    do_load(32'h8000_0000, 32'd1, 1'b1, 1'b1, "midrst_status");

    step(); step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mmio_ctrl
